// File: rtl/matrix_mult_pkg.sv
// Shared definitions for the sequential matrix multiplier: default
// parameters, FSM state encodings and a ceil-log2 helper.
package matrix_mult_pkg;

    localparam int DEF_MAX_SIZE   = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LANES      = 4;
    localparam bit DEF_SIGNED     = 1'b0;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Number of bits needed to index 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Bus bundle between a requester and the sequential matrix multiplier.
//
// Handshake: start is a level request that is sampled on every rising edge
// but only acted on while the engine is idle (busy low). The edge that sees
// start with a valid size latches A, B, matrix_size and sat_en; busy rises
// the next cycle and stays high until the cycle done pulses. A start with a
// size of 0 or above MAX_SIZE produces a one-cycle err pulse instead.
// C is a registered output and is only meaningful once done has pulsed.
interface matrix_mult_seq_if
    import matrix_mult_pkg::*;
#(
    parameter int MAX_SIZE   = DEF_MAX_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int MW = MAX_SIZE * MAX_SIZE * DATA_WIDTH;

    logic          start;
    logic [31:0]   matrix_size;
    logic          sat_en;
    logic [MW-1:0] A;
    logic [MW-1:0] B;
    logic [MW-1:0] C;
    logic          busy;
    logic          done;
    logic          err;
    state_t        dbg_state;

    modport master (
        output start, matrix_size, sat_en, A, B,
        input  C, busy, done, err, dbg_state
    );

    modport slave (
        input  start, matrix_size, sat_en, A, B,
        output C, busy, done, err, dbg_state
    );

endinterface

// File: rtl/matrix_mac_lane.sv
// One multiply-accumulate lane: extends the operand product to the
// accumulator width, accumulates while enabled, and presents the result
// either clamped to the element range or truncated to its low bits.
module matrix_mac_lane
    import matrix_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter bit SIGNED     = DEF_SIGNED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  sat_en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o
);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [ACC_WIDTH-1:0] UMAX =
        {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = ~SMAX;

    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    // Extend operands to full product width so the low PW bits of an
    // unsigned multiply are correct for both signed and unsigned data.
    always_comb begin
        a_ext    = {{DATA_WIDTH{SIGNED & a_i[DATA_WIDTH-1]}}, a_i};
        b_ext    = {{DATA_WIDTH{SIGNED & b_i[DATA_WIDTH-1]}}, b_i};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_WIDTH-PW){SIGNED & prod[PW-1]}}, prod};
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Read-out: clamp to the element range when saturating, else truncate.
    always_comb begin
        res_o = acc_q[DATA_WIDTH-1:0];
        if (sat_en_i) begin
            if (SIGNED) begin
                if ($signed(acc_q) > $signed(SMAX)) begin
                    res_o = SMAX[DATA_WIDTH-1:0];
                end else if ($signed(acc_q) < $signed(SMIN)) begin
                    res_o = SMIN[DATA_WIDTH-1:0];
                end
            end else if (acc_q > UMAX) begin
                res_o = UMAX[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential matrix multiplier C = A * B for an N x N active window of
// MAX_SIZE x MAX_SIZE operands. Each row of C is produced LANES columns at
// a time: N MAC cycles over k, then one STORE cycle that writes the group.
module matrix_mult_seq
    import matrix_mult_pkg::*;
#(
    parameter int MAX_SIZE   = DEF_MAX_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int LANES      = DEF_LANES,
    parameter bit SIGNED     = DEF_SIGNED
) (
    input logic              clk,
    input logic              rst_n,
    matrix_mult_seq_if.slave bus
);
    localparam int MW = MAX_SIZE * MAX_SIZE * DATA_WIDTH;
    // Wide enough for i up to N and for j0 + LANES without wrap.
    localparam int IW = clog2(MAX_SIZE + LANES + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j0_q, j0_d;
    logic [IW-1:0]   k_q, k_d;
    logic [IW-1:0]   n_q, n_d;
    logic            sat_q, sat_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [MW-1:0]   a_q, a_d;
    logic [MW-1:0]   b_q, b_d;
    logic [MW-1:0]   c_q, c_d;

    logic [DATA_WIDTH-1:0] a_op;
    logic [DATA_WIDTH-1:0] b_op     [LANES];
    logic [DATA_WIDTH-1:0] lane_res [LANES];

    logic size_ok;
    logic last_k;
    logic last_grp;
    logic last_row;

    assign size_ok  = (bus.matrix_size != 32'd0) &&
                      (bus.matrix_size <= 32'(MAX_SIZE));
    assign last_k   = (k_q == n_q - IW'(1));
    assign last_grp = ((j0_q + IW'(LANES)) >= n_q);
    assign last_row = (i_q == n_q - IW'(1));

    // Operand fetch: A[i][k] is shared by all lanes, lane l reads B[k][j0+l].
    always_comb begin
        a_op = '0;
        if (int'(i_q) < MAX_SIZE && int'(k_q) < MAX_SIZE) begin
            a_op = a_q[(int'(i_q)*MAX_SIZE + int'(k_q))*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int l = 0; l < LANES; l++) begin
            b_op[l] = '0;
            if (int'(k_q) < MAX_SIZE && int'(j0_q) + l < MAX_SIZE) begin
                b_op[l] = b_q[(int'(k_q)*MAX_SIZE + int'(j0_q) + l)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        matrix_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SIGNED     (SIGNED)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (state_q == ST_STORE),
            .en_i     (state_q == ST_MAC),
            .sat_en_i (sat_q),
            .a_i      (a_op),
            .b_i      (b_op[l]),
            .res_o    (lane_res[l])
        );
    end

    // FSM next-state, index stepping and C write-back.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j0_d    = j0_q;
        k_d     = k_q;
        n_d     = n_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (size_ok) begin
                        state_d = ST_MAC;
                        n_d     = bus.matrix_size[IW-1:0];
                        sat_d   = bus.sat_en;
                        a_d     = bus.A;
                        b_d     = bus.B;
                        c_d     = '0;
                        busy_d  = 1'b1;
                        i_d     = '0;
                        j0_d    = '0;
                        k_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MAC: begin
                if (last_k) begin
                    k_d     = '0;
                    state_d = ST_STORE;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            ST_STORE: begin
                // Lanes past the active width stay silent; the rest of C
                // therefore keeps the zeros written at start.
                for (int l = 0; l < LANES; l++) begin
                    if (int'(j0_q) + l < int'(n_q)) begin
                        c_d[(int'(i_q)*MAX_SIZE + int'(j0_q) + l)*DATA_WIDTH +: DATA_WIDTH] = lane_res[l];
                    end
                end
                if (last_grp) begin
                    j0_d    = '0;
                    i_d     = i_q + IW'(1);
                    state_d = last_row ? ST_DONE : ST_MAC;
                end else begin
                    j0_d    = j0_q + IW'(LANES);
                    state_d = ST_MAC;
                end
            end
            default: begin
                // ST_DONE: one settling cycle, then report completion.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                i_d     = '0;
                j0_d    = '0;
                k_d     = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j0_q    <= '0;
            k_q     <= '0;
            n_q     <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j0_q    <= j0_d;
            k_q     <= k_d;
            n_q     <= n_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    assign bus.C         = c_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/matrix_mult_seq.md
MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 10, maximum matrix dimension.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each A/B/C element.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+8, accumulator width.
REQ-004 SHALL have parameter LANES, default 4, number of C columns computed in parallel (1..MAX_SIZE).
REQ-005 SHALL have parameter SIGNED, default 0, two's-complement arithmetic when 1, unsigned when 0.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port start, input, 1, request to begin a multiplication.
REQ-009 SHALL have port matrix_size, input, 32, active dimension N, sampled with start.
REQ-010 SHALL have port sat_en, input, 1, saturate C elements when 1 and truncate when 0, sampled with start.
REQ-011 SHALL have port A, input, MAX_SIZE*MAX_SIZE*DATA_WIDTH, flattened row-major; element (i,k) at offset (i*MAX_SIZE+k)*DATA_WIDTH.
REQ-012 SHALL have port B, input, same width and layout as A.
REQ-013 SHALL have port C, output, same width and layout as A, registered result.
REQ-014 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when C is complete.
REQ-016 SHALL have port err, output, 1, one-cycle pulse when start is rejected for an invalid size.

Function
REQ-017 SHALL accept start only in IDLE; start while busy SHALL be ignored with no other effect.
REQ-018 SHALL reject start when N=0 or N>MAX_SIZE: err pulses the next cycle, state stays IDLE, C unchanged.
REQ-019 SHALL, on accepted start, latch A, B, N and sat_en, clear all of C to zero, and assert busy from the next cycle.
REQ-020 SHALL use states IDLE -> MAC -> STORE -> (MAC for the next column group | DONE) -> IDLE.
REQ-021 SHALL, in MAC, run N cycles with k=0..N-1; lane l accumulates A[i][k]*B[k][j0+l] into its ACC_WIDTH accumulator, with products sign- or zero-extended per SIGNED.
REQ-022 SHALL, in STORE (1 cycle), write each lane with j0+l<N to C[i][j0+l], clear the accumulators, and advance j0 by LANES, or set j0 to 0 and increment i when j0+LANES>=N.
REQ-023 SHALL leave lanes with j0+l>=N inactive: no write to C.
REQ-024 SHALL keep C elements with i>=N or j>=N at zero.
REQ-025 SHALL, with sat_en=1, clamp each stored value to the DATA_WIDTH range (unsigned 0..2^DW-1 or signed -2^(DW-1)..2^(DW-1)-1); with sat_en=0, store the low DATA_WIDTH bits.
REQ-026 SHALL, with G=ceil(N/LANES), pulse done exactly N*G*(N+1)+1 cycles after the start edge; busy falls in the same cycle.
REQ-027 SHALL hold C stable from done until the next accepted start.
REQ-028 SHALL have no accumulator overflow for N<=MAX_SIZE at default ACC_WIDTH.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, including mid-operation, force state IDLE, busy=0, done=0, err=0, C=0, accumulators=0, and i=j0=k=0.
REQ-030 SHALL accept start in the first cycle after rst_n returns high.

Structure
REQ-031 SHALL keep state encodings, a clog2 function and the default parameter values in shared package matrix_mult_pkg.
REQ-032 SHALL instantiate LANES copies of sub-module matrix_mac_lane (multiply, extend, accumulate, clear, saturate or truncate on read).

Verification
REQ-033 SHALL check N=2, LANES=4, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]], rest zero, done at cycle 7.
REQ-034 SHALL check N=5, LANES=4, A=identity, B(i,j)=10i+j -> C=B, G=2, done at cycle 61.
REQ-035 SHALL check DATA_WIDTH=8, N=1, A=B=200: sat_en=1 -> C[0][0]=255; sat_en=0 -> C[0][0]=64.
REQ-036 SHALL check SIGNED=1, DATA_WIDTH=8, N=1, A=-3, B=5 -> C[0][0]=-15 (0xF1).
REQ-037 SHALL check start with N=0 and with N=MAX_SIZE+1 -> err pulses once, busy stays 0, C unchanged; start while busy -> ignored.
REQ-038 SHALL check rst_n low for 1 cycle during MAC -> next cycle busy=0 and C=0, then a fresh N=2 run gives the REQ-033 result.
